// File: rtl/serial_tx_arbiter.sv
// Round-robin, packet-granular arbiter sharing one 8N1 transmitter among pRequesters byte streams.
// Latency: 1 cycle valid->grant, 1 cycle grant->send strobe, at most one byte every 2 cycles.
// Backpressure: waits on iTxReady with the gap timer frozen; a granted requester idle past pGapTimeout loses the grant.
module serial_tx_arbiter #(
  parameter int pRequesters = 4,
  parameter int pGapTimeout = 1024
) (
  input  logic                     iClock,
  input  logic                     inReset,
  input  logic [pRequesters-1:0]   iReqValid,
  input  logic [8*pRequesters-1:0] iReqData,
  input  logic [pRequesters-1:0]   iReqLast,
  output logic [pRequesters-1:0]   oReqAck,
  output logic [pRequesters-1:0]   oGrant,
  output logic [7:0]               oTxData,
  output logic                     oTxSend,
  input  logic                     iTxReady,
  output logic                     oBusy,
  output logic                     oGapError
);

  localparam int IW = $clog2(pRequesters);
  localparam int GW = (pGapTimeout > 0) ? $clog2(pGapTimeout + 1) : 1;
  localparam logic [31:0] GAP_LIMIT = pGapTimeout;
  localparam logic [pRequesters-1:0] ONE_HOT0 = 1;

  // stRelease is kept in the encoding but never entered; it decodes back to arbitration.
  typedef enum logic [1:0] {ST_ARB, ST_WAIT, ST_GUARD, ST_RELEASE} state_t;

  state_t state_q, state_d;
  logic [IW-1:0] cur_q, cur_d;      // index of the current packet owner
  logic [IW-1:0] ptr_q, ptr_d;      // last granted index, search starts after it
  logic [GW-1:0] gap_q, gap_d;
  logic last_byte_q, last_byte_d;

  logic [pRequesters-1:0] grant_d, ack_d;
  logic [7:0] data_d;
  logic send_d, err_d, busy_d;

  logic [IW-1:0] pick;
  logic any_vld, cur_vld, cur_last, timeout_hit;
  logic [7:0] cur_dat;

  assign any_vld  = |iReqValid;
  assign cur_vld  = iReqValid[cur_q];
  assign cur_last = iReqLast[cur_q];
  assign cur_dat  = iReqData[{cur_q, 3'b000} +: 8];
  assign timeout_hit = (GAP_LIMIT != 32'd0) &&
                       (({{(32-GW){1'b0}}, gap_q} + 32'd1) == GAP_LIMIT);

  // Round-robin search: first valid requester after the previous winner, with wrap.
  always_comb begin
    int c;
    logic found;
    logic [IW-1:0] cand;
    pick  = ptr_q;
    found = 1'b0;
    c     = 0;
    cand  = '0;
    for (int k = 1; k <= pRequesters; k++) begin
      c    = (int'(ptr_q) + k) % pRequesters;
      cand = c[IW-1:0];
      if (!found && iReqValid[cand]) begin
        found = 1'b1;
        pick  = cand;
      end
    end
  end

  // State and registered outputs; reset drops the strobe and grant without waiting for a clock.
  always_ff @(posedge iClock or negedge inReset) begin
    if (!inReset) begin
      state_q     <= ST_ARB;
      cur_q       <= '0;
      ptr_q       <= IW'(pRequesters - 1);
      gap_q       <= '0;
      last_byte_q <= 1'b0;
      oGrant      <= '0;
      oReqAck     <= '0;
      oTxData     <= '0;
      oTxSend     <= 1'b0;
      oBusy       <= 1'b0;
      oGapError   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cur_q       <= cur_d;
      ptr_q       <= ptr_d;
      gap_q       <= gap_d;
      last_byte_q <= last_byte_d;
      oGrant      <= grant_d;
      oReqAck     <= ack_d;
      oTxData     <= data_d;
      oTxSend     <= send_d;
      oBusy       <= busy_d;
      oGapError   <= err_d;
    end
  end

  // Next-state decision.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_ARB:   if (any_vld) state_d = ST_WAIT;
      ST_WAIT: begin
        if (cur_vld && iTxReady)       state_d = ST_GUARD;
        else if (!cur_vld && timeout_hit) state_d = ST_ARB;
      end
      ST_GUARD: state_d = last_byte_q ? ST_ARB : ST_WAIT;
      default:  state_d = ST_ARB;
    endcase
  end

  // Next values of outputs and datapath registers; pulse outputs default low.
  always_comb begin
    grant_d     = oGrant;
    ack_d       = '0;
    data_d      = oTxData;
    send_d      = 1'b0;
    err_d       = 1'b0;
    cur_d       = cur_q;
    ptr_d       = ptr_q;
    gap_d       = gap_q;
    last_byte_d = last_byte_q;
    case (state_q)
      ST_ARB: begin
        if (any_vld) begin
          grant_d = ONE_HOT0 << pick;
          cur_d   = pick;
          ptr_d   = pick;
          gap_d   = '0;
        end
      end
      ST_WAIT: begin
        if (cur_vld && iTxReady) begin
          data_d       = cur_dat;
          send_d       = 1'b1;
          ack_d[cur_q] = 1'b1;
          last_byte_d  = cur_last;
          gap_d        = '0;
        end else if (!cur_vld && (GAP_LIMIT != 32'd0)) begin
          if (timeout_hit) begin
            err_d   = 1'b1;
            grant_d = '0;
            gap_d   = '0;
          end else begin
            gap_d = gap_q + 1'b1;
          end
        end
      end
      ST_GUARD: begin
        // One dead cycle lets the transmitter sample the strobe and drop its ready.
        if (last_byte_q) grant_d = '0;
      end
      default: grant_d = '0;
    endcase
    busy_d = |grant_d;
  end

endmodule

// File: tb/tb_serial_tx_arbiter.sv
// Scoreboard bench for serial_tx_arbiter: directed packets, monitor checks every send strobe.
// Latency: expected bytes are queued at stimulus time and consumed in order of DUT send strobes.
// Backpressure: transmitter ready is held high except during a long mid-packet stall.
module tb_serial_tx_arbiter;
  localparam int N = 4;

  logic iClock = 1'b0;
  logic inReset;
  logic [N-1:0] iReqValid;
  logic [8*N-1:0] iReqData;
  logic [N-1:0] iReqLast;
  logic [N-1:0] oReqAck;
  logic [N-1:0] oGrant;
  logic [7:0] oTxData;
  logic oTxSend;
  logic iTxReady;
  logic oBusy;
  logic oGapError;

  serial_tx_arbiter #(.pRequesters(N), .pGapTimeout(16)) dut (
    .iClock(iClock), .inReset(inReset),
    .iReqValid(iReqValid), .iReqData(iReqData), .iReqLast(iReqLast),
    .oReqAck(oReqAck), .oGrant(oGrant),
    .oTxData(oTxData), .oTxSend(oTxSend), .iTxReady(iTxReady),
    .oBusy(oBusy), .oGapError(oGapError)
  );

  always #5 iClock = ~iClock;

  typedef struct packed {
    logic [1:0] idx;
    logic [7:0] dat;
  } exp_t;

  exp_t exp_q[$];
  logic [8:0] pkt [N][$];
  int send_log[$];
  int send_cyc [N];
  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int gap_cnt = 0;
  logic tx_hold = 1'b0;
  logic prev_send = 1'b0;
  exp_t mon_e;

  assign iTxReady = ~tx_hold;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic exp_t mk(input int idx, input int dat);
    exp_t e;
    e.idx = idx[1:0];
    e.dat = dat[7:0];
    return e;
  endfunction

  always @(posedge iClock) cyc <= cyc + 1;

  // Monitor: every send strobe consumes one scoreboard entry.
  always @(negedge iClock) begin
    if (oGapError) gap_cnt++;
    if (oTxSend) begin
      check("no_back_to_back_send", {31'd0, prev_send}, 32'd0);
      check("ack_matches_grant", {28'd0, oReqAck}, {28'd0, oGrant});
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_send: got data %0h grant %0b, expected no send", oTxData, oGrant);
      end else begin
        mon_e = exp_q.pop_front();
        check("tx_data", {24'd0, oTxData}, {24'd0, mon_e.dat});
        check("tx_grant", {28'd0, oGrant}, 32'd1 << mon_e.idx);
      end
      send_log.push_back(cyc);
      for (int r = 0; r < N; r++) if (oGrant[r]) send_cyc[r] = cyc;
    end else if (oReqAck != '0) begin
      checks++;
      errors++;
      $display("FAIL ack_without_send: got ack %0b, expected 0", oReqAck);
    end
    prev_send = oTxSend;
  end

  // Requester model: presents the head of each packet queue, advances on ack.
  initial begin
    iReqValid = '0;
    iReqData  = '0;
    iReqLast  = '0;
    forever begin
      @(posedge iClock);
      #1;
      for (int r = 0; r < N; r++) begin
        logic [8:0] w;
        if (oReqAck[r] && pkt[r].size() > 0) void'(pkt[r].pop_front());
        if (pkt[r].size() > 0) begin
          w = pkt[r][0];
          iReqValid[r] = 1'b1;
          iReqData[8*r +: 8] = w[7:0];
          iReqLast[r] = w[8];
        end else begin
          iReqValid[r] = 1'b0;
          iReqLast[r] = 1'b0;
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  function automatic bit all_empty();
    for (int r = 0; r < N; r++) if (pkt[r].size() > 0) return 1'b0;
    return exp_q.size() == 0;
  endfunction

  task automatic wait_idle(input string name, input int budget);
    int n;
    bit done;
    n = 0;
    done = 1'b0;
    while (!done && n < budget) begin
      @(negedge iClock);
      n++;
      done = all_empty() && !oBusy;
    end
    check({name, "_done"}, {31'd0, done}, 32'd1);
    check({name, "_grant_idle"}, {28'd0, oGrant}, 32'd0);
  endtask

  task automatic wait_busy(input string name, input int budget, input logic [3:0] exp_grant);
    int n;
    n = 0;
    while (!oBusy && n < budget) begin
      @(negedge iClock);
      n++;
    end
    check({name, "_grant"}, {28'd0, oGrant}, {28'd0, exp_grant});
  endtask

  task automatic do_reset();
    inReset = 1'b0;
    for (int r = 0; r < N; r++) pkt[r].delete();
    exp_q.delete();
    repeat (3) @(negedge iClock);
    inReset = 1'b1;
    @(negedge iClock);
  endtask

  initial begin
    int n;
    int g0;
    inReset = 1'b1;
    #3;
    inReset = 1'b0;
    #1;
    check("rst_grant", {28'd0, oGrant}, 32'd0);
    check("rst_send", {31'd0, oTxSend}, 32'd0);
    check("rst_ack", {28'd0, oReqAck}, 32'd0);
    check("rst_data", {24'd0, oTxData}, 32'd0);
    check("rst_busy", {31'd0, oBusy}, 32'd0);
    check("rst_gap", {31'd0, oGapError}, 32'd0);
    repeat (3) @(negedge iClock);
    inReset = 1'b1;
    @(negedge iClock);

    // Single two-byte packet from requester 1.
    exp_q.push_back(mk(1, 'h55));
    exp_q.push_back(mk(1, 'hA3));
    pkt[1] = '{9'h055, 9'h1A3};
    wait_busy("single", 20, 4'b0010);
    wait_idle("single", 40);

    // Contention from reset: 0, 2, 3, then 0 again.
    do_reset();
    exp_q.push_back(mk(0, 'h01)); exp_q.push_back(mk(0, 'h02));
    exp_q.push_back(mk(2, 'h21)); exp_q.push_back(mk(2, 'h22));
    exp_q.push_back(mk(3, 'h31)); exp_q.push_back(mk(3, 'h32));
    exp_q.push_back(mk(0, 'h03)); exp_q.push_back(mk(0, 'h04));
    pkt[0] = '{9'h001, 9'h102, 9'h003, 9'h104};
    pkt[2] = '{9'h021, 9'h122};
    pkt[3] = '{9'h031, 9'h132};
    wait_idle("contention", 100);

    // Transmitter stall mid-packet: grant held, no send, no timeout.
    send_log.delete();
    exp_q.push_back(mk(1, 'h11)); exp_q.push_back(mk(1, 'h12)); exp_q.push_back(mk(1, 'h13));
    pkt[1] = '{9'h011, 9'h012, 9'h113};
    n = 0;
    while (send_log.size() < 1 && n < 30) begin
      @(negedge iClock);
      n++;
    end
    tx_hold = 1'b1;
    g0 = gap_cnt;
    repeat (500) @(negedge iClock);
    check("stall_sends", send_log.size(), 32'd1);
    check("stall_no_gap", gap_cnt, g0);
    check("stall_grant", {28'd0, oGrant}, 32'b0010);
    tx_hold = 1'b0;
    wait_idle("stall", 40);
    check("stall_total_sends", send_log.size(), 32'd3);

    // Back-to-back: one byte every 2 cycles.
    send_log.delete();
    for (int i = 0; i < 6; i++) exp_q.push_back(mk(0, 'hA0 + i));
    pkt[0] = '{9'h0A0, 9'h0A1, 9'h0A2, 9'h0A3, 9'h0A4, 9'h1A5};
    wait_idle("b2b", 60);
    check("b2b_count", send_log.size(), 32'd6);
    if (send_log.size() == 6) check("b2b_span", send_log[5] - send_log[0], 32'd10);

    // Gap timeout: requester 2 stalls after a non-last byte, requester 3 follows.
    g0 = gap_cnt;
    exp_q.push_back(mk(2, 'h2A));
    exp_q.push_back(mk(3, 'h3B)); exp_q.push_back(mk(3, 'h3C));
    pkt[2] = '{9'h02A};
    pkt[3] = '{9'h03B, 9'h13C};
    n = 0;
    while (!oGapError && n < 100) begin
      @(negedge iClock);
      n++;
    end
    check("gap_seen", {31'd0, oGapError}, 32'd1);
    check("gap_grant_cleared", {28'd0, oGrant}, 32'd0);
    check("gap_delay", cyc - send_cyc[2], 32'd17);
    @(negedge iClock);
    check("gap_next_grant", {28'd0, oGrant}, 32'b1000);
    wait_idle("gap", 40);
    check("gap_count", gap_cnt - g0, 32'd1);

    // Asynchronous reset during the guard cycle.
    do_reset();
    exp_q.push_back(mk(1, 'h71));
    pkt[1] = '{9'h071, 9'h072, 9'h173};
    n = 0;
    while (!oTxSend && n < 20) begin
      @(negedge iClock);
      n++;
    end
    check("areset_guard_reached", {31'd0, oTxSend}, 32'd1);
    #2;
    inReset = 1'b0;
    #1;
    check("areset_send", {31'd0, oTxSend}, 32'd0);
    check("areset_grant", {28'd0, oGrant}, 32'd0);
    check("areset_ack", {28'd0, oReqAck}, 32'd0);
    check("areset_busy", {31'd0, oBusy}, 32'd0);
    for (int r = 0; r < N; r++) pkt[r].delete();
    exp_q.delete();
    repeat (3) @(negedge iClock);
    inReset = 1'b1;
    @(negedge iClock);
    exp_q.push_back(mk(0, 'h0A));
    exp_q.push_back(mk(1, 'h1B));
    pkt[0] = '{9'h10A};
    pkt[1] = '{9'h11B};
    wait_busy("after_reset", 20, 4'b0001);
    wait_idle("after_reset", 40);

    check("total_gap_errors", gap_cnt, 32'd1);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/serial_tx_arbiter.md
Name: serial_tx_arbiter

Overview:
- Shares one 8N1 serial transmitter between pRequesters byte-stream sources.
- Arbitration is round-robin at packet granularity. A grant holds until the requester's last byte, or until the requester stalls past a gap timeout.
- Sits between the requester logic (debug/status/telemetry streams) and the transmitter's iData/iSend/oReady handshake.

Parameters:
- pRequesters, 4: number of requesters, 2..8.
- pGapTimeout, 1024: clock cycles a granted requester may hold iReqValid low mid-packet before the grant is revoked. 0 disables the timeout.

Ports:
- iClock  in  1  system clock; all logic on posedge.
- inReset  in  1  asynchronous, active-low reset.
- iReqValid  in  pRequesters  requester r has a byte on its slice of iReqData.
- iReqData  in  8*pRequesters  byte of requester r in bits [8r+7:8r].
- iReqLast  in  pRequesters  presented byte is the last of its packet.
- oReqAck  out  pRequesters  one-cycle pulse: requester r's byte was taken; it may present the next byte after this cycle.
- oGrant  out  pRequesters  one-hot, current packet owner; all zero when no owner.
- oTxData  out  8  byte to the transmitter.
- oTxSend  out  1  one-cycle send strobe to the transmitter.
- iTxReady  in  1  transmitter ready to take a byte.
- oBusy  out  1  a packet is in progress (oGrant != 0).
- oGapError  out  1  one-cycle pulse when a grant is revoked by timeout.

Behaviour:
- Reset: asynchronous on inReset=0. Values while in reset:
  - oReqAck=0, oGrant=0, oTxData=0, oTxSend=0, oBusy=0, oGapError=0
  - state=stArb, gap counter=0
  - round-robin pointer cLast=pRequesters-1, so requester 0 wins first.
- Reset asserted mid-packet drops the send strobe and the grant immediately. No partial-packet recovery; the transmitter finishes any frame it already accepted.
- All outputs are registered.
- Four states: stArb, stWait, stGuard, stRelease.
- stArb:
  - If any iReqValid bit is 1, pick the first r with iReqValid[r]=1, searching cLast+1, cLast+2, … with modulo wrap.
  - Then set oGrant[r]=1, cLast<=r, clear gap counter, go to stWait.
  - Otherwise stay in stArb.
  - Arbitration latency: 1 cycle from valid to grant.
- stWait (g = granted index):
  - If iReqValid[g]=1 and iTxReady=1:
    - register oTxData<=iReqData[g], oTxSend<=1, oReqAck[g]<=1
    - capture iReqLast[g] into cLastByte
    - go to stGuard.
  - Else if iReqValid[g]=0: gap counter +1. When the counter reaches pGapTimeout (pGapTimeout≠0), pulse oGapError, clear oGrant, go to stArb.
  - iTxReady=0 with valid=1 does not advance the counter.
  - The counter clears on every accepted byte.
- stGuard (exactly 1 cycle; oTxSend and oReqAck high during it):
  - Clear oTxSend and oReqAck.
  - If cLastByte=1: clear oGrant, go to stArb. Otherwise go to stWait.
  - The guard guarantees the transmitter has sampled iSend and dropped oReady before the next check. Consequently oTxSend is never high on two consecutive cycles.
- stRelease is reserved and unreachable. It is encoded and decoded to stArb.
- Throughput: a granted, always-valid requester gets a byte at every transmitter ready window, minimum 2 cycles per byte at the arbiter.
- After a packet, the new packet starts from the next index. A sole active requester regrants itself.
- Simultaneous valid from several requesters resolves only by round-robin order. Valid of non-granted requesters is ignored during a packet.
- Byte ordering is preserved per requester. Bytes from different packets never interleave.
- A single-byte packet (valid and last together) costs arb + wait + guard.
- oBusy is equal to |oGrant.

Test Plan:
- Single packet: requester 1 sends 0x55, 0xA3(last), tx model ready -> oGrant=0010, oTxData 0x55 then 0xA3, two oTxSend pulses, grant drops after guard.
- Contention: requesters 0,2,3 all valid with 2-byte packets from reset -> order 0,2,3, then 0 again if still valid; no interleaving.
- Handshake: tx model holds iTxReady low 500 cycles mid-packet -> no oTxSend, no oGapError, counter stays 0; resumes on ready.
- Gap timeout: pGapTimeout=16, requester 2 sends one non-last byte then drops valid -> oGapError pulses 16 cycles after entering stWait, oGrant=0, requester 3 granted next cycle if valid.
- Back-to-back: always-valid requester 0 with ready forced high -> oTxSend never high on two consecutive cycles, every oReqAck coincides with oTxSend.
- Async reset: drop inReset during stGuard -> oTxSend, oGrant, oReqAck go to 0 without a clock edge; after release requester 0 has priority.
